// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the MEM stage
package mem_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - load lane extract/extend and store data replication
import mem_pkg::*;

module mem_lane_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] store_in,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_data = {24'h0, byte_sel};
            F3_LHU:  load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        store_data = store_in;
        case (funct3[1:0])
            2'b00:   store_data = {4{store_in[7:0]}};
            2'b01:   store_data = {2{store_in[15:0]}};
            default: store_data = store_in;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: access decode, dmem handshake, MEM/WB register
import mem_pkg::*;

module mem_access_stage (
    input  logic            clk_i,
    input  logic            start_i,
    input  logic [31:0]     ALUResult_i,
    input  logic [31:0]     RDData_i,
    input  logic [4:0]      RDaddr_i,
    input  logic            RegWrite_i,
    input  logic            MemToReg_i,
    input  logic            MemRead_i,
    input  logic            MemWrite_i,
    input  logic [31:0]     instr_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [31:0]     dmem_addr_o,
    output logic [BE_W-1:0] dmem_be_o,
    output logic [31:0]     dmem_wdata_o,
    input  logic            dmem_ready_i,
    input  logic            dmem_rvalid_i,
    input  logic [31:0]     dmem_rdata_i,
    output logic            Stall_o,
    output logic            err_o,
    output logic [31:0]     ALUResult_o,
    output logic [31:0]     MemData_o,
    output logic [4:0]      RDaddr_o,
    output logic            RegWrite_o,
    output logic            MemToReg_o
);

    mem_state_t  state;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic        mem_op;
    logic        legal_f3;
    logic        misaligned;
    logic        fault;
    logic        start_ok;
    logic        store_done;
    logic        load_done;
    logic [31:0] load_data;
    logic        unused_instr;

    assign funct3       = instr_i[14:12];
    assign addr_lo      = ALUResult_i[1:0];
    assign mem_op       = MemRead_i | MemWrite_i;
    assign unused_instr = ^{instr_i[31:15], instr_i[11:0]};

    always_comb begin
        legal_f3 = 1'b0;
        if (MemRead_i)
            legal_f3 = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        else
            legal_f3 = funct3 inside {F3_SB, F3_SH, F3_SW};
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    end

    // Faults are only judged on first sight of the op, never mid-access.
    assign fault      = (state == ST_IDLE) && mem_op &&
                        ((MemRead_i && MemWrite_i) || !legal_f3 || misaligned);
    assign start_ok   = (state == ST_IDLE) && mem_op && !fault;
    assign store_done = (state == ST_REQ) && dmem_ready_i && MemWrite_i;
    assign load_done  = (state == ST_WAIT_R) && dmem_rvalid_i;
    assign Stall_o    = start_ok ||
                        ((state != ST_IDLE) && !(store_done || load_done));

    assign dmem_req_o  = (state == ST_REQ);
    assign dmem_we_o   = dmem_req_o && MemWrite_i;
    assign dmem_addr_o = {ALUResult_i[31:2], 2'b00};

    always_comb begin
        dmem_be_o = 4'b1111;
        case (funct3[1:0])
            2'b00:   dmem_be_o = 4'b0001 << addr_lo;
            2'b01:   dmem_be_o = 4'b0011 << {addr_lo[1], 1'b0};
            default: dmem_be_o = 4'b1111;
        endcase
    end

    mem_lane_align u_align (
        .funct3     (funct3),
        .addr_lo    (addr_lo),
        .rdata      (dmem_rdata_i),
        .store_in   (RDData_i),
        .load_data  (load_data),
        .store_data (dmem_wdata_o)
    );

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state       <= ST_IDLE;
            err_o       <= 1'b0;
            ALUResult_o <= 32'h0;
            MemData_o   <= 32'h0;
            RDaddr_o    <= 5'h0;
            RegWrite_o  <= 1'b0;
            MemToReg_o  <= 1'b0;
        end else begin
            err_o <= fault;
            case (state)
                ST_IDLE:   if (start_ok) state <= ST_REQ;
                ST_REQ:    if (dmem_ready_i) state <= MemWrite_i ? ST_IDLE : ST_WAIT_R;
                ST_WAIT_R: if (dmem_rvalid_i) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
            if (load_done)
                MemData_o <= load_data;
            if (Stall_o) begin
                RegWrite_o <= 1'b0;
            end else begin
                ALUResult_o <= ALUResult_i;
                RDaddr_o    <= RDaddr_i;
                RegWrite_o  <= RegWrite_i && !fault;
                MemToReg_o  <= MemToReg_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        start_i;
    logic [31:0] ALUResult_i, RDData_i, instr_i, dmem_rdata_i;
    logic [4:0]  RDaddr_i;
    logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i;
    logic        dmem_ready_i, dmem_rvalid_i;
    logic        dmem_req_o, dmem_we_o, Stall_o, err_o, RegWrite_o, MemToReg_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, ALUResult_o, MemData_o;
    logic [3:0]  dmem_be_o;
    logic [4:0]  RDaddr_o;

    int errors = 0;
    int checks = 0;

    int          st, rq;
    bit          stab;
    logic [31:0] ca, cw;
    logic [3:0]  cb;
    logic        cwe;

    always #5 clk_i = ~clk_i;

    mem_access_stage dut (
        .clk_i(clk_i), .start_i(start_i),
        .ALUResult_i(ALUResult_i), .RDData_i(RDData_i), .RDaddr_i(RDaddr_i),
        .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .instr_i(instr_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .Stall_o(Stall_o), .err_o(err_o), .ALUResult_o(ALUResult_o), .MemData_o(MemData_o),
        .RDaddr_o(RDaddr_o), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rdaddr, input logic regw, input logic m2r);
        MemRead_i   = rd;
        MemWrite_i  = wr;
        instr_i     = {17'h0, f3, 12'h003};
        ALUResult_i = addr;
        RDData_i    = data;
        RDaddr_i    = rdaddr;
        RegWrite_i  = regw;
        MemToReg_i  = m2r;
    endtask

    task automatic set_nop();
        set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0);
    endtask

    // Memory responder: op inputs are set by the caller in cycle 0; ready comes rw
    // cycles into REQ, rvalid vw cycles into WAIT_R. Returns after the completing edge.
    task automatic access(input bit is_load, input int rw, input int vw, input logic [31:0] rd,
                          output int stalls, output int reqs, output bit stable,
                          output logic [31:0] a, output logic [3:0] b,
                          output logic [31:0] w, output logic we);
        int total;
        total  = 2 + rw + (is_load ? vw + 1 : 0);
        stalls = 0; reqs = 0; stable = 1'b1;
        a = 32'h0; b = 4'h0; w = 32'h0; we = 1'b0;
        for (int t = 0; t < total; t++) begin
            if (t > 0) tick();
            dmem_ready_i  = (t == rw + 1);
            dmem_rvalid_i = is_load && (t == rw + 2 + vw);
            dmem_rdata_i  = dmem_rvalid_i ? rd : 32'h0;
            @(negedge clk_i);
            if (Stall_o) stalls++;
            if (dmem_req_o) begin
                if (reqs == 0) begin
                    a = dmem_addr_o; b = dmem_be_o; w = dmem_wdata_o; we = dmem_we_o;
                end else if (a !== dmem_addr_o || b !== dmem_be_o ||
                             w !== dmem_wdata_o || we !== dmem_we_o) begin
                    stable = 1'b0;
                end
                reqs++;
            end
        end
        tick();
        dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    endtask

    task automatic test_reset();
        start_i = 1'b0;
        set_nop();
        dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (2) @(negedge clk_i);
        checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", dmem_req_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
        checks++; if (Stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", Stall_o); end
        checks++; if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite_o); end
        checks++; if (MemData_o !== 32'h0 || ALUResult_o !== 32'h0) begin errors++;
            $display("FAIL reset_data got=%h/%h exp=0/0", MemData_o, ALUResult_o); end
        tick();
        start_i = 1'b1;
    endtask

    task automatic test_lw();
        tick();
        set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1);
        access(1'b1, 0, 0, 32'hDEADBEEF, st, rq, stab, ca, cb, cw, cwe);
        set_nop();
        checks++; if (st !== 2) begin errors++; $display("FAIL lw_stall_cycles got=%0d exp=2", st); end
        checks++; if (rq !== 1 || ca !== 32'h100 || cb !== 4'b1111 || cwe !== 1'b0) begin errors++;
            $display("FAIL lw_request got=req%0d addr=%h be=%b we=%b exp=req1 addr=100 be=1111 we=0", rq, ca, cb, cwe); end
        @(negedge clk_i);
        checks++; if (MemData_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", MemData_o); end
        checks++; if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd5 || MemToReg_o !== 1'b1 || ALUResult_o !== 32'h100) begin errors++;
            $display("FAIL lw_wb got=rw%b rd%0d m2r%b alu=%h exp=rw1 rd5 m2r1 alu=100", RegWrite_o, RDaddr_o, MemToReg_o, ALUResult_o); end
        tick();
        @(negedge clk_i);
        checks++; if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL lw_regwrite_once got=%b exp=0", RegWrite_o); end
    endtask

    task automatic test_lb_lbu();
        set_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1'b1, 1'b1);
        access(1'b1, 0, 0, 32'h80FF0000, st, rq, stab, ca, cb, cw, cwe);
        set_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1);
        #1;
        checks++; if (cb !== 4'b1000 || ca !== 32'h100) begin errors++; $display("FAIL lb_be got=%b addr=%h exp=1000 addr=100", cb, ca); end
        checks++; if (MemData_o !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signext got=%h exp=ffffff80", MemData_o); end
        access(1'b1, 0, 0, 32'h80FF0000, st, rq, stab, ca, cb, cw, cwe);
        set_nop();
        #1;
        checks++; if (MemData_o !== 32'h00000080) begin errors++; $display("FAIL lbu_zeroext got=%h exp=00000080", MemData_o); end
        tick();
    endtask

    task automatic test_sh_wait();
        set_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0, 1'b0, 1'b0);
        access(1'b0, 3, 0, 32'h0, st, rq, stab, ca, cb, cw, cwe);
        set_nop();
        checks++; if (st !== 4) begin errors++; $display("FAIL sh_stall_cycles got=%0d exp=4", st); end
        checks++; if (rq !== 4 || stab !== 1'b1) begin errors++; $display("FAIL sh_req_held got=req%0d stable=%b exp=req4 stable=1", rq, stab); end
        checks++; if (cb !== 4'b1100 || cw !== 32'hABCDABCD || cwe !== 1'b1 || ca !== 32'h200) begin errors++;
            $display("FAIL sh_lanes got=be%b wd=%h we=%b addr=%h exp=be1100 wd=abcdabcd we=1 addr=200", cb, cw, cwe, ca); end
        #1;
        checks++; if (ALUResult_o !== 32'h202 || RegWrite_o !== 1'b0) begin errors++;
            $display("FAIL sh_wb got=alu=%h rw=%b exp=alu=202 rw=0", ALUResult_o, RegWrite_o); end
        tick();
    endtask

    task automatic test_fault();
        set_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd9, 1'b1, 1'b1);
        @(negedge clk_i);
        checks++; if (Stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin errors++;
            $display("FAIL fault_no_access got=stall%b req%b exp=stall0 req0", Stall_o, dmem_req_o); end
        tick();
        set_nop();
        @(negedge clk_i);
        checks++; if (err_o !== 1'b1 || RegWrite_o !== 1'b0 || ALUResult_o !== 32'h101 || dmem_req_o !== 1'b0) begin errors++;
            $display("FAIL fault_pulse got=err%b rw%b alu=%h req%b exp=err1 rw0 alu=101 req0", err_o, RegWrite_o, ALUResult_o, dmem_req_o); end
        tick();
        @(negedge clk_i);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL fault_one_cycle got=%b exp=0", err_o); end
        tick();
    endtask

    task automatic test_reset_abort();
        set_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd4, 1'b1, 1'b1);
        dmem_ready_i = 1'b1;
        tick();
        tick();
        dmem_ready_i = 1'b0;
        start_i = 1'b0;
        set_nop();
        @(negedge clk_i);
        checks++; if (Stall_o !== 1'b0 || dmem_req_o !== 1'b0 || MemData_o !== 32'h0 || ALUResult_o !== 32'h0) begin errors++;
            $display("FAIL abort_outputs got=stall%b req%b md=%h alu=%h exp=all zero", Stall_o, dmem_req_o, MemData_o, ALUResult_o); end
        tick();
        start_i = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h00000BAD;
        tick();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i = 32'h0;
        @(negedge clk_i);
        checks++; if (MemData_o !== 32'h0 || Stall_o !== 1'b0) begin errors++;
            $display("FAIL abort_late_rvalid got=md=%h stall=%b exp=md=0 stall=0", MemData_o, Stall_o); end
        tick();
        set_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 5'd8, 1'b1, 1'b1);
        access(1'b1, 1, 1, 32'h55AA1234, st, rq, stab, ca, cb, cw, cwe);
        set_nop();
        #1;
        checks++; if (st !== 4 || MemData_o !== 32'h55AA1234 || RegWrite_o !== 1'b1) begin errors++;
            $display("FAIL abort_next_load got=stalls%0d md=%h rw=%b exp=stalls4 md=55aa1234 rw=1", st, MemData_o, RegWrite_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        set_op(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd3, 1'b1, 1'b0);
        @(negedge clk_i);
        checks++; if (Stall_o !== 1'b0) begin errors++; $display("FAIL add_no_stall got=%b exp=0", Stall_o); end
        tick();
        set_op(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0);
        #1;
        checks++; if (ALUResult_o !== 32'h77 || RegWrite_o !== 1'b1 || RDaddr_o !== 5'd3) begin errors++;
            $display("FAIL add_wb got=alu=%h rw=%b rd=%0d exp=alu=77 rw=1 rd=3", ALUResult_o, RegWrite_o, RDaddr_o); end
        access(1'b0, 0, 0, 32'h0, st, rq, stab, ca, cb, cw, cwe);
        set_op(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 5'd10, 1'b1, 1'b1);
        checks++; if (st !== 1 || cw !== 32'hCAFEF00D || cb !== 4'b1111 || cwe !== 1'b1) begin errors++;
            $display("FAIL sw_b2b got=stalls%0d wd=%h be=%b we=%b exp=stalls1 wd=cafef00d be=1111 we=1", st, cw, cb, cwe); end
        #1;
        checks++; if (ALUResult_o !== 32'h40) begin errors++; $display("FAIL sw_wb got=%h exp=40", ALUResult_o); end
        access(1'b1, 0, 0, 32'h0BADF00D, st, rq, stab, ca, cb, cw, cwe);
        set_nop();
        #1;
        checks++; if (st !== 2 || ca !== 32'h44 || MemData_o !== 32'h0BADF00D || RDaddr_o !== 5'd10) begin errors++;
            $display("FAIL lw_b2b got=stalls%0d addr=%h md=%h rd=%0d exp=stalls2 addr=44 md=0badf00d rd=10", st, ca, MemData_o, RDaddr_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_wait();
        test_fault();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage consumer of the EX/MEM pipeline register's outputs. It decodes load and store accesses from the latched EX/MEM fields and runs a request/response handshake to data memory. It holds the pipeline with `Stall_o` (fed back to the `Stall` inputs of the upstream pipeline registers) until the access completes, and it registers the MEM/WB fields.

## Interface
- No parameters; all datapaths fixed at 32 bits.
- `clk_i`  in  1  clock, rising edge.
- `start_i`  in  1  reset, asynchronous, active-low.
- `ALUResult_i`  in  32  effective address (memory ops) or ALU result.
- `RDData_i`  in  32  store data.
- `RDaddr_i`  in  5  destination register.
- `RegWrite_i`, `MemToReg_i`, `MemRead_i`, `MemWrite_i`  in  1 each  EX/MEM control bits.
- `instr_i`  in  32  instruction; `funct3 = instr_i[14:12]`.
- `dmem_req_o`  out  1  request valid.
- `dmem_we_o`  out  1  1 = store.
- `dmem_addr_o`  out  32  `{ALUResult_i[31:2], 2'b00}`.
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  32  lane-replicated store data.
- `dmem_ready_i`  in  1  memory accepts request.
- `dmem_rvalid_i`  in  1  read data valid.
- `dmem_rdata_i`  in  32  read word.
- `Stall_o`  out  1  combinational pipeline hold.
- `err_o`  out  1  registered one-cycle access-fault pulse.
- `ALUResult_o`, `MemData_o`  out  32 each  MEM/WB data.
- `RDaddr_o`  out  5  MEM/WB destination register.
- `RegWrite_o`, `MemToReg_o`  out  1 each  MEM/WB control.

## Operation
- FSM states: IDLE, REQ, WAIT_R.
- Memory op = `MemRead_i | MemWrite_i`.
- Legal funct3:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
- Fault conditions, checked in IDLE:
  - `MemRead_i & MemWrite_i` both set;
  - illegal funct3;
  - halfword with `addr[0] = 1`;
  - word with `addr[1:0] != 0`.
- On a fault: no memory request, no stall. Next edge: `err_o = 1`, `RegWrite_o = 0`, other MEM/WB fields captured.
- IDLE, legal memory op: go to REQ.
- REQ: `dmem_req_o = 1`; addr, be, we and wdata held stable until `dmem_ready_i`.
  - Store accepted: go to IDLE.
  - Load accepted: go to WAIT_R.
- WAIT_R: on `dmem_rvalid_i`, capture the aligned load result into `MemData_o`, then go to IDLE.
- `dmem_rvalid_i` is ignored outside WAIT_R.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`;
  - half: `4'b0011 << {addr[1], 1'b0}`;
  - word: `4'b1111`.
- Store data: byte replicated ×4, half replicated ×2, word unchanged.
- Load extract: select lane by `addr[1:0]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- `Stall_o = 1` in both of these cases, else 0:
  - IDLE with a legal memory op;
  - REQ or WAIT_R, except the completing cycle (REQ & ready & store, or WAIT_R & rvalid).
- MEM/WB register on each edge:
  - `Stall_o = 0`: capture `ALUResult_i`, `RDaddr_i`, `RegWrite_i`, `MemToReg_i`.
  - `Stall_o = 1`: bubble (`RegWrite_o <= 0`), other fields hold.
- Non-memory instructions pass through in one cycle with no stall.

## Timing
- Reset values: state IDLE, `dmem_req_o = 0`, `err_o = 0`, all MEM/WB outputs 0.
- Reset during REQ/WAIT_R aborts the access immediately. A late `dmem_rvalid_i` is then ignored.
- Zero-wait memory (`ready = 1` in REQ, `rvalid` the following cycle):
  - Load: `Stall_o` high 2 cycles; result visible on `MemData_o` 3 edges after the op appears.
  - Store: `Stall_o` high 1 cycle; 2 edges total.
- Each wait cycle on `dmem_ready_i` or `dmem_rvalid_i` adds exactly one stall cycle.
- Inputs are stable during REQ/WAIT_R because the EX/MEM register is frozen by `Stall_o`.
- Back-to-back memory ops: IDLE after completion sees the next instruction, with no idle gap cycle.

## Structure
- Shared package `mem_pkg`:
  - funct3 constants (LB…SW);
  - state enum `mem_state_t`;
  - byte-enable width constant.
- Sub-module `mem_lane_align`: combinational load lane select plus sign/zero extension, and store data replication. The FSM, fault check and MEM/WB registers stay in the top.

## Test plan
- LW `addr = 0x100`, zero-wait memory, `rdata = 0xDEADBEEF` -> `Stall_o` high 2 cycles, `MemData_o = 0xDEADBEEF`, `RegWrite_o = 1` once.
- LB `addr = 0x103`, `rdata = 0x80FF_0000` -> `be = 4'b1000`, `MemData_o = 0xFFFFFF80`; the same access as LBU -> `0x00000080`.
- SH `addr = 0x202`, `RDData_i = 0x1234ABCD`, `ready` delayed 3 cycles -> `be = 4'b1100`, `wdata = 0xABCDABCD`, `Stall_o` high 4 cycles, `dmem_req_o` held throughout.
- LW `addr = 0x101` -> no `dmem_req_o`, no stall, `err_o` one-cycle pulse, `RegWrite_o = 0`.
- `start_i` low during WAIT_R, `rvalid` arrives after reset release -> outputs zero, `rvalid` ignored, the next load completes normally.
- Non-memory ADD followed by back-to-back SW then LW -> ADD written with no stall, store and load complete with no idle gap between them.
